// File: rtl/div_unit.sv
// div_unit: iterative radix-2 non-restoring divider for RV32M DIV/DIVU/REM/REMU.
// Takes one operation at a time. The result is held on the CDB request until it is granted.
module div_unit #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             execute,
  input  logic [WIDTH:0]   src1,
  input  logic [WIDTH:0]   src2,
  input  logic [1:0]       divControl,
  input  logic [ROB:0]     instrRob,
  input  logic             clear,
  input  logic             dataBusGrant,
  output logic             busy,
  output logic             dataBusReq,
  output logic [WIDTH:0]   result,
  output logic [ROB:0]     robEntry
);

  localparam int DW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, CORRECT, DONE} state_t;

  state_t         state_q, state_d;
  logic [DW:0]    p_q, p_d;          // signed partial remainder, one guard bit
  logic [WIDTH:0] q_q, q_d;          // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH:0] d_q, d_d;          // divisor magnitude
  logic [5:0]     cnt_q, cnt_d;
  logic           rem_q, rem_d;      // 1: return remainder, 0: quotient
  logic           negq_q, negq_d;    // negate quotient at the end
  logic           negr_q, negr_d;    // negate remainder at the end
  logic [ROB:0]   rob_q, rob_d;
  logic [WIDTH:0] result_q, result_d;

  // Issue-side operand decode
  logic           is_signed, is_rem, src1_neg, src2_neg, div_zero, overflow;
  logic [WIDTH:0] abs1, abs2, min_int;

  assign is_signed = ~divControl[0];
  assign is_rem    = divControl[1];
  assign src1_neg  = is_signed & src1[WIDTH];
  assign src2_neg  = is_signed & src2[WIDTH];
  assign abs1      = src1_neg ? -src1 : src1;
  assign abs2      = src2_neg ? -src2 : src2;
  assign min_int   = {1'b1, {WIDTH{1'b0}}};
  assign div_zero  = (src2 == '0);
  assign overflow  = is_signed & (src1 == min_int) & (&src2);

  // One non-restoring step: shift {P,Q} left, add or subtract D by the sign of P
  logic [DW:0]    p_sh, d_ext, p_step;
  assign p_sh   = {p_q[DW-1:0], q_q[WIDTH]};
  assign d_ext  = {1'b0, d_q};
  assign p_step = p_q[DW] ? (p_sh + d_ext) : (p_sh - d_ext);

  // Final correction: restore a negative remainder, then apply the result signs
  logic [WIDTH:0] rem_fix, rem_out, quo_out;
  assign rem_fix = p_q[DW] ? (p_q[WIDTH:0] + d_q) : p_q[WIDTH:0];
  assign rem_out = negr_q ? -rem_fix : rem_fix;
  assign quo_out = negq_q ? -q_q : q_q;

  // Next-state and datapath update for the IDLE/DIVIDE/CORRECT/DONE sequence
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    q_d      = q_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    rob_d    = rob_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (execute && !clear) begin
          rob_d = instrRob;
          rem_d = is_rem;
          if (div_zero) begin
            result_d = is_rem ? src1 : '1;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = is_rem ? '0 : min_int;
            state_d  = DONE;
          end else begin
            p_d     = '0;
            q_d     = abs1;
            d_d     = abs2;
            cnt_d   = '0;
            negq_d  = src1_neg ^ src2_neg;
            negr_d  = src1_neg;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        p_d   = p_step;
        q_d   = {q_q[WIDTH-1:0], ~p_step[DW]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH)) state_d = CORRECT;
      end
      CORRECT: begin
        result_d = rem_q ? rem_out : quo_out;
        state_d  = DONE;
      end
      DONE: begin
        if (dataBusGrant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush discards whatever is in flight or queued
    if (clear) state_d = IDLE;
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      state_q  <= IDLE;
      p_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      rob_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      q_q      <= q_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      rob_q    <= rob_d;
      result_q <= result_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign dataBusReq = (state_q == DONE) & ~clear;
  assign result     = result_q;
  assign robEntry   = rob_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 non-restoring divider functional unit that executes RV32M DIV/DIVU/REM/REMU. It sits beside the ALU and branch units: a divide reservation station issues one operation, the unit computes for a fixed number of cycles, then requests the common data bus and holds its result until granted. A control-flow flush (`clear`) aborts any in-flight operation.

## Interface
- WIDTH, 31: data MSB index; operands and results are WIDTH+1 = 32 bits.
- ROB, 2: ROB tag MSB index; tags are ROB+1 bits.
- clk  input  1  rising-edge clock.
- globalReset  input  1  asynchronous, active-low reset.
- execute  input  1  issue strobe from the divide RS; honoured only when `busy`=0.
- src1  input  WIDTH+1  dividend.
- src2  input  WIDTH+1  divisor.
- divControl  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- instrRob  input  ROB+1  ROB tag of the issued instruction.
- clear  input  1  flush from commit (controlFlow[0]).
- dataBusGrant  input  1  CDB arbiter grant for this unit.
- busy  output  1  unit occupied; the RS must not issue.
- dataBusReq  output  1  CDB request; result and tag valid while high.
- result  output  WIDTH+1  quotient or remainder.
- robEntry  output  ROB+1  tag of the result.

## Operation
- States: IDLE, DIVIDE, CORRECT, DONE.
- IDLE: busy=0. On an edge with execute=1 and clear=0, latch the operands, op and tag.
  - Divide-by-zero (src2=0): result = all-ones for DIV/DIVU; result = src1 for REM/REMU. Go to DONE.
  - Signed overflow (DIV/REM, src1=0x80000000, src2=0xFFFFFFFF): result = 0x80000000 for DIV, 0 for REM. Go to DONE.
  - Otherwise load magnitudes and go to DIVIDE. Signed ops take |src|; unsigned ops use operands as-is.
- DIVIDE: 33-bit partial remainder P, initialised 0; 32-bit quotient register Q, initialised to |dividend|; 6-bit counter, initialised 0. Each cycle:
  - shift {P,Q} left by 1;
  - if P was non-negative, P = P − D, else P = P + D;
  - the new Q LSB = ~P[32].
  - After counter reaches 31, go to CORRECT.
- CORRECT, one cycle:
  - if P is negative, P = P + D;
  - quotient is negated if signed and the operand signs differ;
  - remainder takes the dividend's sign if signed;
  - select quotient or remainder by op, latch into `result`, go to DONE.
- DONE: dataBusReq=1; result and robEntry are stable. On an edge with dataBusGrant=1, go to IDLE.
- busy = (state != IDLE).
- clear=1 at any edge forces IDLE; the queued result is discarded. dataBusReq is gated combinationally by ~clear, so no broadcast happens in a flush cycle. execute in the same cycle as clear is ignored.
- Reset (globalReset=0): state IDLE, counter 0, P/Q 0. Outputs: busy=0, dataBusReq=0, result=0, robEntry=0. Reset mid-operation aborts without a request.

## Timing
- Normal op: issue edge E0. DIVIDE spans edges E1..E32, CORRECT at E33. dataBusReq is high after E33, so there are 34 cycles from issue to request.
- Special cases: dataBusReq is high after E0, a 1-cycle latency.
- Grant at edge Eg: dataBusReq and busy are low after Eg. The next issue is accepted at Eg+1 at the earliest; there is no issue in the grant cycle.
- Stalled grant: DONE holds indefinitely with outputs unchanged.
- One operation in flight; no pipelining.

## Test plan
- DIV 100/7, tag 3: dataBusReq rises 34 cycles after issue, result=14, robEntry=3. REM of the same operands gives 2.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF. REMU 0xFFFFFFFF/16 → 15.
- Division by zero: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Both after 1 cycle. Overflow: DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- Hold dataBusGrant low for 5 cycles in DONE: result, robEntry and dataBusReq stay constant. Grant → busy=0 next cycle. Issue on the following cycle is accepted.
- Assert clear on the 10th DIVIDE cycle: next cycle busy=0. No dataBusReq ever appears for that tag. A fresh issue then completes correctly. clear together with dataBusReq in DONE: no request is visible and the unit returns to IDLE.
- Drive globalReset low asynchronously mid-DIVIDE: busy, dataBusReq, result and robEntry go to 0 immediately, without waiting for a clock edge. execute while busy=1 is ignored, so the latched tag and operands are unchanged.
